sha_padder: RTL and testbench

SHA_PADDER -- requirements
Module: sha_padder

---
 rtl/sha_padder.sv | 161 ++++++++++++++++
 tb/tb_sha_padder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha_padder.sv
// -----------------------------------------------------------------------------
// sha_padder
//   Byte-stream to 512-bit block padder for SHA-1/SHA-256 style compression.
//   Bytes are packed big-endian into a 64-byte buffer. After the final message
//   byte a single 0x80 marker is placed, the rest of the block is zero-filled,
//   and the 64-bit message length in bits is written to bytes 56..63. When the
//   marker or the length does not fit, a second (extra) block carries them.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   in_data    message byte
//   in_valid   in_data valid
//   in_last    in_data is the final message byte (qualified by in_valid)
//   in_ready   padder accepts a byte this cycle
//   blk_data   padded block, byte 0 at [511:504]
//   blk_valid  blk_data valid
//   blk_last   block is the final block of the message (qualified by blk_valid)
//   blk_ready  consumer takes the block this cycle
// -----------------------------------------------------------------------------
module sha_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ready
);

    typedef enum logic [1:0] {FILL, PAD, XTRA, EMIT} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [511:0]   blk_buf;
    logic [6:0]     idx;        // next byte slot, 0..64
    logic [63:0]    len_bits;   // message length so far, wraps modulo 2^64
    logic           msg_done;   // final byte has been absorbed
    logic           mark_done;  // 0x80 marker already placed in an earlier block
    logic           final_blk;  // buffer holds the last block of the message
    logic           in_fire;
    logic           blk_fire;

    assign in_fire  = in_valid && in_ready;
    assign blk_fire = blk_valid && blk_ready;

    // Marker at byte pos, zeros after it, and the length in the tail when the
    // marker left room for all eight length bytes.
    function automatic logic [511:0] pad_block(input logic [511:0] cur,
                                               input logic [6:0]   pos,
                                               input logic [63:0]  len);
        logic [511:0] r;
        r = cur;
        for (int i = 0; i < 64; i++) begin
            if (7'(i) == pos)
                r[511 - 8*i -: 8] = 8'h80;
            else if (7'(i) > pos)
                r[511 - 8*i -: 8] = 8'h00;
        end
        if (pos <= 7'd55)
            r[63:0] = len;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (in_fire) begin
                    if (idx == 7'd63)
                        state_nxt = EMIT;
                    else if (in_last)
                        state_nxt = PAD;
                end
            end
            PAD:  state_nxt = EMIT;
            XTRA: state_nxt = EMIT;
            EMIT: begin
                if (blk_fire)
                    state_nxt = (final_blk || !msg_done) ? FILL : XTRA;
            end
        endcase
    end

    // Outputs: purely a function of state and the held buffer, so they stay
    // stable for the whole time a block waits on blk_ready.
    always_comb begin
        in_ready  = (state == FILL);
        blk_valid = (state == EMIT);
        blk_last  = (state == EMIT) && final_blk;
        blk_data  = blk_buf;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide block buffer is reset as well, so blk_data reads
            // zero after reset and nothing of an aborted message survives.
            blk_buf   <= '0;
            idx       <= '0;
            len_bits  <= '0;
            msg_done  <= 1'b0;
            mark_done <= 1'b0;
            final_blk <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_fire) begin
                        blk_buf[9'd504 - {idx[5:0], 3'b000} +: 8] <= in_data;
                        idx      <= idx + 7'd1;
                        len_bits <= len_bits + 64'd8;
                        if (in_last)
                            msg_done <= 1'b1;
                    end
                end
                PAD: begin
                    blk_buf   <= pad_block(blk_buf, idx, len_bits);
                    mark_done <= 1'b1;
                    if (idx <= 7'd55)
                        final_blk <= 1'b1;
                end
                XTRA: begin
                    // Marker lands here only when the message filled the
                    // previous block exactly.
                    blk_buf   <= {(mark_done ? 8'h00 : 8'h80), 440'd0, len_bits};
                    final_blk <= 1'b1;
                end
                EMIT: begin
                    if (blk_fire) begin
                        if (final_blk) begin
                            idx       <= '0;
                            len_bits  <= '0;
                            msg_done  <= 1'b0;
                            mark_done <= 1'b0;
                            final_blk <= 1'b0;
                        end else if (!msg_done) begin
                            idx <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_padder.sv
// -----------------------------------------------------------------------------
// tb_sha_padder
//   Self-checking bench for sha_padder. Expected blocks come from a reference
//   model that pads a byte queue the textbook way (append 0x80, zero-fill to
//   56 mod 64, append 64-bit bit length) and slices it into 64-byte blocks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    int           tests = 0;
    int           fails = 0;
    logic [511:0] last_blk;   // most recent block accepted by run_msg

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};

    always #5 clk = ~clk;

    sha_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one message and consume its blocks, comparing against the model.
    // vpct/rpct: percent chance of in_valid / blk_ready per cycle;
    // stall: cycles blk_ready is forced low at the start of every block.
    task automatic run_msg(input string name, input logic [7:0] msg[$],
                           input int vpct, input int rpct, input int stall);
        logic [7:0]   p[$];
        logic [511:0] exp_blk[$];
        logic         exp_last[$];
        logic [63:0]  len;
        logic [511:0] blk;
        logic [511:0] held;
        logic         was_last;
        int           pos, cyc, ref_cyc, exp_dly, vcnt, nblk;
        bit           prev_valid, prev_stall, in_fire, blk_fire;

        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[503:0], p[64*b + j]};
            exp_blk.push_back(blk);
            exp_last.push_back(b == nblk - 1);
        end

        pos = 0; cyc = 0; ref_cyc = 0; exp_dly = 0; vcnt = 0;
        prev_valid = 0; prev_stall = 0; held = '0;
        while ((pos < msg.size() || exp_blk.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (blk_valid && !prev_valid) begin
                check({name, " latency"}, 512'(cyc - ref_cyc), 512'(exp_dly));
                check({name, " in_ready during emit"}, 512'(in_ready), 512'(0));
            end
            if (prev_stall) begin
                check({name, " held blk_valid"}, 512'(blk_valid), 512'(1));
                check({name, " held blk_data"}, blk_data, held);
            end

            in_valid  = (pos < msg.size()) && (int'($urandom_range(99)) < vpct);
            in_data   = in_valid ? msg[pos] : 8'($urandom);
            in_last   = in_valid ? (pos == msg.size() - 1) : 1'($urandom);
            blk_ready = blk_valid ? (vcnt >= stall && int'($urandom_range(99)) < rpct)
                                  : 1'($urandom);
            in_fire   = in_valid && in_ready;
            blk_fire  = blk_valid && blk_ready;

            if (in_fire) begin
                pos++;
                if (pos % 64 == 0) begin
                    ref_cyc = cyc; exp_dly = 1;
                end else if (pos == msg.size()) begin
                    ref_cyc = cyc; exp_dly = 2;
                end
            end
            if (blk_fire) begin
                if (exp_blk.size() == 0) begin
                    check({name, " unexpected block"}, 512'(blk_valid), 512'(0));
                end else begin
                    was_last = exp_last.pop_front();
                    check({name, " blk_data"}, blk_data, exp_blk.pop_front());
                    check({name, " blk_last"}, 512'(blk_last), 512'(was_last));
                    last_blk = blk_data;
                    if (!was_last && pos == msg.size()) begin
                        ref_cyc = cyc; exp_dly = 2;
                    end
                end
                vcnt = 0;
            end else if (blk_valid) begin
                vcnt++;
            end
            prev_stall = blk_valid && !blk_ready;
            held       = blk_data;
            prev_valid = blk_valid && !blk_fire;
        end
        check({name, " bytes left"}, 512'(msg.size() - pos), 512'(0));
        check({name, " blocks left"}, 512'(exp_blk.size()), 512'(0));

        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        check({name, " idle in_ready"}, 512'(in_ready), 512'(1));
        check({name, " idle blk_valid"}, 512'(blk_valid), 512'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 512'(in_ready), 512'(1));
        check("reset blk_valid", 512'(blk_valid), 512'(0));
        check("reset blk_last", 512'(blk_last), 512'(0));
        check("reset blk_data", blk_data, 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // "abc", always ready
        m = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", m, 100, 100, 0);
        check("abc block", last_blk, ABC_BLK);

        // 55 bytes: marker and length share the single block
        m.delete();
        repeat (55) m.push_back(8'h41);
        run_msg("len55", m, 100, 100, 0);
        check("len55 block", last_blk, {{55{8'h41}}, 8'h80, 64'h1B8});

        // 56 bytes: marker in block 1, length alone in block 2
        m.delete();
        repeat (56) m.push_back(8'h41);
        run_msg("len56", m, 100, 100, 0);
        check("len56 block2", last_blk, {448'd0, 64'h1C0});

        // 64 bytes: full data block, then marker + length block
        m.delete();
        repeat (64) m.push_back(8'h00);
        run_msg("len64", m, 100, 100, 0);
        check("len64 block2", last_blk, {8'h80, 440'd0, 64'h200});

        // "abc" with 5 cycles of back-pressure on the block
        m = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_stall", m, 100, 100, 5);
        check("abc_stall block", last_blk, ABC_BLK);

        // Reset after 30 bytes, then "abc" must come out clean
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midmsg rst blk_valid", 512'(blk_valid), 512'(0));
        check("midmsg rst blk_data", blk_data, 512'(0));
        check("midmsg rst in_ready", 512'(in_ready), 512'(1));
        @(negedge clk);
        rst = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_after_rst", m, 100, 100, 0);
        check("abc_after_rst block", last_blk, ABC_BLK);

        // Reset while a block is waiting in EMIT
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = m[i]; in_last = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("emit wait blk_valid", 512'(blk_valid), 512'(1));
        check("emit wait blk_data", blk_data, ABC_BLK);
        #1 rst = 1'b1;
        #1;
        check("emit rst blk_valid", 512'(blk_valid), 512'(0));
        check("emit rst blk_last", 512'(blk_last), 512'(0));
        check("emit rst blk_data", blk_data, 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst in_ready", 512'(in_ready), 512'(1));
        check("post rst blk_valid", 512'(blk_valid), 512'(0));

        // Random messages under random valid/ready patterns
        for (int t = 0; t < 20; t++) begin
            int n;
            n = int'($urandom_range(150, 1));
            m.delete();
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            run_msg($sformatf("rand%0d_len%0d", t, n), m,
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
